// File: rtl/alsu_seq_pkg.sv
// Shared types and constants for the ALSU front-end sequencer: opcode field
// widths, the group-to-select map and the controller state codes.
package alsu_seq_pkg;

   localparam int OPC_W  = 6;
   localparam int GRP_W  = 3;
   localparam int SUB_W  = 3;
   localparam int DATA_W = 4;
   localparam int SEL_W  = 4;

   localparam logic [SUB_W-1:0] SUB_MAX         = 3'd4;
   localparam logic [7:0]       ITER_GROUP_MASK = 8'b1100_0000;

   // Entry [g] is the datapath mux select for opcode group g.
   localparam logic [7:0][SEL_W-1:0] GROUP_SEL = {
      4'b1100, 4'b1110, 4'b1000, 4'b0101,
      4'b1010, 4'b0110, 4'b0010, 4'b0000
   };

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_ISSUE = 2'd1;
   localparam state_t S_WAIT  = 2'd2;
   localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/alsu_op_decode.sv
// Combinational opcode decoder: splits {group, sub} into the datapath select,
// sub-function, legality and whether the group runs as repeated 1-bit passes.
module alsu_op_decode
   import alsu_seq_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic [SEL_W-1:0] sel,
   output logic [SUB_W-1:0] func,
   output logic             legal,
   output logic             iterative
);

   logic [GRP_W-1:0] grp;

   assign grp       = opcode[OPC_W-1:SUB_W];
   assign func      = opcode[SUB_W-1:0];
   assign sel       = GROUP_SEL[grp];
   assign legal     = (func <= SUB_MAX);
   assign iterative = ITER_GROUP_MASK[grp];

endmodule

// File: rtl/alsu_op_sequencer.sv
// Front-end controller for the 4-bit ALSU: accepts one request, drives the
// datapath for one pass (or one pass per shift bit), then holds the result.
module alsu_op_sequencer
   import alsu_seq_pkg::*;
#(
   parameter int ALSU_LAT  = 1,
   parameter int MAX_SHAMT = 7
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OPC_W-1:0]  req_opcode,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic [SEL_W-1:0]  alsu_sel,
   output logic [SUB_W-1:0]  alsu_func,
   output logic [DATA_W-1:0] alsu_a,
   output logic [DATA_W-1:0] alsu_b,
   input  logic [DATA_W-1:0] alsu_result,
   input  logic              alsu_cout,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_cout,
   output logic              res_err
);

   state_t            state;
   logic [1:0]        lat_cnt;
   logic [2:0]        shamt_rem;
   logic              iter_op;
   logic [SEL_W-1:0]  dec_sel;
   logic [SUB_W-1:0]  dec_func;
   logic              dec_legal;
   logic              dec_iter;
   logic [2:0]        req_shamt;

   alsu_op_decode u_decode (
      .opcode    (req_opcode),
      .sel       (dec_sel),
      .func      (dec_func),
      .legal     (dec_legal),
      .iterative (dec_iter)
   );

   assign req_shamt = (req_b[2:0] > 3'(MAX_SHAMT)) ? 3'(MAX_SHAMT) : req_b[2:0];

   // Gated by rst so the host never sees a ready while reset is held.
   assign req_ready = (state == S_IDLE) && !rst;
   assign res_valid = (state == S_DONE);

   // Datapath operands are loaded on every entry to ISSUE and held through WAIT;
   // iterative passes feed the sampled result back in as the next operand A.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         lat_cnt   <= '0;
         shamt_rem <= '0;
         iter_op   <= 1'b0;
         alsu_sel  <= '0;
         alsu_func <= '0;
         alsu_a    <= '0;
         alsu_b    <= '0;
         res_data  <= '0;
         res_cout  <= 1'b0;
         res_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (!dec_legal) begin
                     res_err  <= 1'b1;
                     res_data <= '0;
                     res_cout <= 1'b0;
                     state    <= S_DONE;
                  end else if (dec_iter && (req_shamt == 3'd0)) begin
                     res_err  <= 1'b0;
                     res_data <= req_a;
                     res_cout <= 1'b0;
                     state    <= S_DONE;
                  end else begin
                     alsu_sel  <= dec_sel;
                     alsu_func <= dec_func;
                     alsu_a    <= req_a;
                     alsu_b    <= req_b;
                     iter_op   <= dec_iter;
                     shamt_rem <= req_shamt;
                     state     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               lat_cnt <= 2'(ALSU_LAT - 1);
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (lat_cnt != 2'd0) begin
                  lat_cnt <= lat_cnt - 2'd1;
               end else begin
                  res_data <= alsu_result;
                  res_cout <= alsu_cout;
                  res_err  <= 1'b0;
                  if (iter_op) begin
                     shamt_rem <= shamt_rem - 3'd1;
                     alsu_a    <= alsu_result;
                     state     <= (shamt_rem > 3'd1) ? S_ISSUE : S_DONE;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alsu_op_sequencer.sv
// Randomized bench for alsu_op_sequencer against a behavioural model of the
// opcode rules, with a registered one-cycle datapath stub (add / shl / rol).
module tb_alsu_op_sequencer;

   localparam int LAT = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [5:0] req_opcode;
   logic [3:0] req_a;
   logic [3:0] req_b;
   logic [3:0] alsu_sel;
   logic [2:0] alsu_func;
   logic [3:0] alsu_a;
   logic [3:0] alsu_b;
   logic [3:0] alsu_result;
   logic       alsu_cout;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic       res_cout;
   logic       res_err;

   int passCount  = 0;
   int checkCount = 0;
   int lastSel    = 0;
   int selMap [8] = '{0, 2, 6, 10, 5, 8, 14, 12};

   alsu_op_sequencer #(.ALSU_LAT(LAT), .MAX_SHAMT(7)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_opcode  (req_opcode),
      .req_a       (req_a),
      .req_b       (req_b),
      .alsu_sel    (alsu_sel),
      .alsu_func   (alsu_func),
      .alsu_a      (alsu_a),
      .alsu_b      (alsu_b),
      .alsu_result (alsu_result),
      .alsu_cout   (alsu_cout),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_cout    (res_cout),
      .res_err     (res_err)
   );

   always #5 clk = ~clk;

   // Datapath stub with one register stage: shift-left for 1110, rotate-left for 1100, add otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alsu_result <= '0;
         alsu_cout   <= 1'b0;
      end else if (alsu_sel == 4'b1110) begin
         alsu_result <= {alsu_a[2:0], 1'b0};
         alsu_cout   <= alsu_a[3];
      end else if (alsu_sel == 4'b1100) begin
         alsu_result <= {alsu_a[2:0], alsu_a[3]};
         alsu_cout   <= alsu_a[3];
      end else begin
         {alsu_cout, alsu_result} <= {1'b0, alsu_a} + {1'b0, alsu_b};
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   function automatic void refModel(input int opc, input int a, input int b,
                                    output int expData, output int expCout,
                                    output int expErr, output int expLat,
                                    output bit issues);
      int grp, sub, shamt, av, sum;
      grp = opc / 8;
      sub = opc % 8;
      expData = 0; expCout = 0; expErr = 0; issues = 0;
      if (sub > 4) begin
         expErr = 1;
         expLat = 1;
      end else if (grp >= 6) begin
         shamt = b % 8;
         if (shamt == 0) begin
            expData = a;
            expLat  = 1;
         end else begin
            av = a;
            for (int i = 0; i < shamt; i++) begin
               expCout = av / 8;
               av = (av * 2) % 16;
               if (grp == 7) av = av + expCout;
            end
            expData = av;
            expLat  = shamt * (LAT + 1) + 1;
            issues  = 1;
         end
      end else begin
         sum     = a + b;
         expData = sum % 16;
         expCout = sum / 16;
         expLat  = LAT + 2;
         issues  = 1;
      end
   endfunction

   task automatic applyStimulus(input logic [5:0] opc, input logic [3:0] a, input logic [3:0] b,
                                input int holdCycles, input bit readyEarly);
      int expData, expCout, expErr, expLat, expSel, n, selBad, stableBad;
      bit issues;
      refModel(int'(opc), int'(a), int'(b), expData, expCout, expErr, expLat, issues);
      expSel = issues ? selMap[opc[5:3]] : lastSel;

      @(negedge clk);
      checkOutput("req_ready_idle", int'(req_ready), 1);
      req_valid  = 1'b1;
      req_opcode = opc;
      req_a      = a;
      req_b      = b;
      res_ready  = readyEarly;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_opcode = 6'($urandom);
      req_a      = 4'($urandom);
      req_b      = 4'($urandom);

      n = 0;
      selBad = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) checkOutput("alsu_sel_first", int'(alsu_sel), expSel);
         if (!res_valid && issues && (int'(alsu_sel) != expSel || int'(alsu_func) != int'(opc[2:0])))
            selBad++;
      end while (!res_valid && n < 64);
      if (issues) lastSel = expSel;

      checkOutput("latency", n, expLat);
      checkOutput("sel_func_hold", selBad, 0);
      checkOutput("res_data", int'(res_data), expData);
      checkOutput("res_cout", int'(res_cout), expCout);
      checkOutput("res_err", int'(res_err), expErr);

      if (readyEarly) begin
         @(negedge clk);
         checkOutput("one_cycle_valid", int'(res_valid), 0);
         checkOutput("ready_after_done", int'(req_ready), 1);
      end else begin
         stableBad = 0;
         for (int i = 0; i < holdCycles; i++) begin
            req_valid = ~req_valid;
            @(negedge clk);
            if (!res_valid || int'(res_data) != expData || int'(res_err) != expErr || req_ready)
               stableBad++;
         end
         checkOutput("done_hold_stable", stableBad, 0);
         req_valid = 1'b0;
         res_ready = 1'b1;
         @(negedge clk);
         checkOutput("valid_after_release", int'(res_valid), 0);
         checkOutput("ready_after_release", int'(req_ready), 1);
      end
      res_ready = 1'b0;
   endtask

   initial begin
      int resetValidSeen;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      res_ready  = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("rst_req_ready", int'(req_ready), 0);
      checkOutput("rst_res_valid", int'(res_valid), 0);
      checkOutput("rst_alsu_sel", int'(alsu_sel), 0);
      checkOutput("rst_res_data", int'(res_data), 0);
      checkOutput("rst_res_err", int'(res_err), 0);
      rst = 1'b0;
      #1;
      checkOutput("req_ready_after_reset", int'(req_ready), 1);

      applyStimulus(6'b000_111, 4'h5, 4'h2, 1, 1'b0);
      applyStimulus(6'b001_010, 4'h3, 4'h5, 2, 1'b0);
      applyStimulus(6'b110_000, 4'b1001, 4'd3, 0, 1'b1);
      applyStimulus(6'b111_011, 4'hA, 4'h8, 0, 1'b0);
      applyStimulus(6'b010_100, 4'h7, 4'h9, 5, 1'b0);
      applyStimulus(6'b111_100, 4'b1011, 4'd7, 1, 1'b0);

      for (int k = 0; k < 40; k++)
         applyStimulus(6'($urandom), 4'($urandom), 4'($urandom),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      // Reset pulsed while an iterative op is in its first WAIT.
      @(negedge clk);
      req_valid  = 1'b1;
      req_opcode = 6'b110_001;
      req_a      = 4'b0110;
      req_b      = 4'd5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midop_res_valid", int'(res_valid), 0);
      checkOutput("midop_req_ready", int'(req_ready), 0);
      checkOutput("midop_alsu_sel", int'(alsu_sel), 0);
      checkOutput("midop_alsu_a", int'(alsu_a), 0);
      checkOutput("midop_alsu_b", int'(alsu_b), 0);
      checkOutput("midop_alsu_func", int'(alsu_func), 0);
      checkOutput("midop_res_data", int'(res_data), 0);
      lastSel = 0;
      @(negedge clk);
      rst = 1'b0;
      resetValidSeen = 0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid) resetValidSeen++;
      end
      checkOutput("no_result_after_reset", resetValidSeen, 0);
      applyStimulus(6'b011_001, 4'hC, 4'h6, 1, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
